// File: rtl/bcd_ex3_seq_ctrl_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencer.
// Holds the FSM state encoding and digit-level constants.
package bcd_ex3_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] BAD_NIBBLE = 4'hF;

endpackage

// File: rtl/bcd_ex3_seq_ctrl_if.sv
// Producer/consumer handshake bundle for the BCD to Excess-3 sequencer.
// The slave modport is the sequencer side.
interface bcd_ex3_seq_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_ex3;
  logic                  out_err;
  logic                  busy;

  modport master (
    output in_valid,
    output in_bcd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_ex3,
    input  out_err,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_bcd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_ex3,
    output out_err,
    output busy
  );

endinterface

// File: rtl/bcd_ex3_seq_ctrl_digit_ex3.sv
// Single-digit BCD to Excess-3 converter, shared by every digit slot.
// Non-BCD digits map to the bad-nibble marker and raise invalid.
module bcd_digit_ex3
  import bcd_ex3_seq_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] ex3,
  output logic       invalid
);

  always_comb begin
    invalid = (digit > 4'd9);
    ex3     = invalid ? BAD_NIBBLE : digit + EX3_OFFSET;
  end

endmodule

// File: rtl/bcd_ex3_seq_ctrl.sv
// Word-level sequencer: streams BCD digits LSB-first through one
// shared digit converter and presents the Excess-3 word.
module bcd_ex3_seq_ctrl
  import bcd_ex3_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input logic              clk,
  input logic              rst,
  bcd_ex3_seq_ctrl_if.slave bus
);

  state_t              state;
  logic [4*DIGITS-1:0] src;
  logic [4*DIGITS-1:0] res;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic                in_rdy;
  logic                out_vld;
  logic                bsy;
  logic [3:0]          dig;
  logic [3:0]          ex3;
  logic                bad;

  always_comb begin
    dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CNT_W'(i)) dig = src[i*4 +: 4];
    end
  end

  bcd_digit_ex3 u_dig (
    .digit   (dig),
    .ex3     (ex3),
    .invalid (bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      src     <= '0;
      res     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      bsy     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            src    <= bus.in_bcd;
            res    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            in_rdy <= 1'b0;
            bsy    <= 1'b1;
            state  <= ST_CONV;
          end
        end
        ST_CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) res[i*4 +: 4] <= ex3;
          end
          err <= err | bad;
          if (cnt == CNT_W'(DIGITS-1)) begin
            out_vld <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            bsy     <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_ex3   = res;
  assign bus.out_err   = err;
  assign bus.busy      = bsy;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Directed and random checks of the BCD to Excess-3 sequencer
// against a digit-arithmetic reference model.
module tb_bcd_ex3_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bcd_ex3_seq_ctrl_if #(.DIGITS(4)) b4 ();
  bcd_ex3_seq_ctrl_if #(.DIGITS(1)) b1 ();

  bcd_ex3_seq_ctrl #(.DIGITS(4), .CNT_W(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  bcd_ex3_seq_ctrl #(.DIGITS(1), .CNT_W(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input int w, input int nd,
                       output logic [15:0] r, output logic e);
    int d;
    int acc;
    acc = 0;
    e = 1'b0;
    for (int i = 0; i < nd; i++) begin
      d = (w >> (4*i)) % 16;
      if (d > 9) begin
        e = 1'b1;
        acc = acc + (15 << (4*i));
      end else begin
        acc = acc + ((d + 3) << (4*i));
      end
    end
    r = 16'(acc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_word(input logic [15:0] w, input int stall);
    int n;
    logic [15:0] exp;
    logic e;
    model(int'(w), 4, exp, e);
    n = 0;
    while (!b4.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(b4.in_ready), 1);
    b4.out_ready = (stall == 0);
    b4.in_valid = 1'b1;
    b4.in_bcd = w;
    step();
    b4.in_valid = 1'b0;
    b4.in_bcd = 16'($urandom);
    chk("busy_conv", 32'(b4.busy), 1);
    chk("in_ready_conv", 32'(b4.in_ready), 0);
    n = 0;
    while (!b4.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 4);
    chk("ex3", 32'(b4.out_ex3), 32'(exp));
    chk("err", 32'(b4.out_err), 32'(e));
    for (int s = 0; s < stall; s++) begin
      b4.in_valid = 1'b1;
      b4.in_bcd = 16'($urandom);
      step();
      chk("hold_valid", 32'(b4.out_valid), 1);
      chk("hold_ex3", 32'(b4.out_ex3), 32'(exp));
      chk("hold_err", 32'(b4.out_err), 32'(e));
      chk("hold_in_ready", 32'(b4.in_ready), 0);
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    step();
    chk("valid_drop", 32'(b4.out_valid), 0);
    chk("in_ready_idle", 32'(b4.in_ready), 1);
    chk("busy_idle", 32'(b4.busy), 0);
    chk("ex3_kept", 32'(b4.out_ex3), 32'(exp));
  endtask

  initial begin
    logic [15:0] exp;
    logic e;
    b4.in_valid = 1'b0;
    b4.in_bcd = '0;
    b4.out_ready = 1'b1;
    b1.in_valid = 1'b0;
    b1.in_bcd = '0;
    b1.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(b4.out_valid), 0);
    chk("rst_ex3", 32'(b4.out_ex3), 0);
    chk("rst_err", 32'(b4.out_err), 0);
    chk("rst_busy", 32'(b4.busy), 0);
    chk("rst_in_ready", 32'(b4.in_ready), 1);

    do_word(16'h1234, 0);
    chk("w1234", 32'(b4.out_ex3), 32'h4567);
    do_word(16'h9900, 0);
    chk("w9900", 32'(b4.out_ex3), 32'hCC33);
    do_word(16'h0000, 0);
    chk("w0000", 32'(b4.out_ex3), 32'h3333);
    do_word(16'h12A4, 0);
    chk("w12a4", 32'(b4.out_ex3), 32'h45F7);
    chk("w12a4_err", 32'(b4.out_err), 1);
    do_word(16'h0001, 0);
    chk("w0001", 32'(b4.out_ex3), 32'h3334);
    chk("w0001_err", 32'(b4.out_err), 0);
    do_word(16'h8765, 5);

    b4.in_valid = 1'b1;
    b4.in_bcd = 16'h5678;
    step();
    b4.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(b4.out_valid), 0);
    chk("mid_rst_ex3", 32'(b4.out_ex3), 0);
    chk("mid_rst_err", 32'(b4.out_err), 0);
    chk("mid_rst_busy", 32'(b4.busy), 0);
    chk("mid_rst_in_ready", 32'(b4.in_ready), 1);
    do_word(16'h0102, 0);
    chk("w0102", 32'(b4.out_ex3), 32'h3435);

    for (int k = 0; k < 24; k++) begin
      do_word(16'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 16; i++) begin
      model(i, 1, exp, e);
      b1.in_valid = 1'b1;
      b1.in_bcd = 4'(i);
      step();
      b1.in_valid = 1'b0;
      b1.in_bcd = 4'($urandom);
      chk("d1_conv", 32'(b1.out_valid), 0);
      step();
      chk("d1_valid", 32'(b1.out_valid), 1);
      chk("d1_ex3", 32'(b1.out_ex3), 32'(exp));
      chk("d1_err", 32'(b1.out_err), 32'(e));
      step();
      chk("d1_in_ready", 32'(b1.in_ready), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_ex3_seq_ctrl.md
Name: bcd_ex3_seq_ctrl

Overview:
- Sequencer that converts a packed multi-digit BCD word to Excess-3.
- Streams the digits one per clock, least-significant first, through a single shared 4-bit BCD-to-Excess-3 digit converter.
- Sits between a BCD producer and an Excess-3 consumer, with valid/ready handshakes on both sides.
- Flags any non-BCD digit (value above 9) in the word.

Parameters:
- DIGITS, 4, number of BCD digits per word (at least 1).
- CNT_W, 3, width of the digit counter (must satisfy 2^CNT_W > DIGITS-1).

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, producer has a word on in_bcd.
- in_ready, output, 1, block can accept a word.
- in_bcd, input, 4*DIGITS, packed BCD word; digit 0 is in bits [3:0].
- out_valid, output, 1, out_ex3 and out_err are valid.
- out_ready, input, 1, consumer accepts the result.
- out_ex3, output, 4*DIGITS, packed Excess-3 result; same digit order as in_bcd.
- out_err, output, 1, at least one input digit was above 9.
- busy, output, 1, high in CONV or DONE.

Behaviour:
- Reset, when rst=1 at a rising edge:
  - state goes to IDLE.
  - out_ex3, out_err, out_valid, busy and the digit counter all go to 0.
  - in_ready is 1 in the cycle after reset.
  - Reset has priority over every other event, including mid-CONV and mid-DONE; any in-flight word is discarded with no output.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - If in_valid=1 at an edge: latch in_bcd into the source register, clear the result register, counter and error flag, and go to CONV.
- CONV:
  - in_ready=0, busy=1.
  - Each edge: digit[cnt] goes through the converter, its output is written to result nibble cnt, and err |= (digit > 9).
  - An invalid digit writes 4'hF into its result nibble.
  - The digit converter maps a valid digit d to d+3 in 4-bit arithmetic (0→3, 9→C).
  - When cnt == DIGITS-1, this edge also moves to DONE; otherwise cnt increments.
- DONE:
  - out_valid=1, busy=1; out_ex3 and out_err are held stable.
  - On the edge where out_ready=1: go to IDLE and clear out_valid. out_ex3 keeps its last value until the next accept.
- Timing:
  - A word accepted at edge k has out_valid high from edge k+DIGITS onward.
  - The earliest next accept is at the edge after the output handshake, giving a minimum period of DIGITS+2 cycles per word.
- in_valid and in_bcd are ignored outside IDLE. in_bcd is sampled only at the accepting edge; later changes do not affect the result.
- out_ready is ignored outside DONE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid; both are pure state decodes.
- DIGITS=1: CONV lasts exactly one cycle.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2.
  - EX3_OFFSET=4'd3 and BAD_NIBBLE=4'hF.
- One sub-module, bcd_digit_ex3:
  - combinational, 4-bit in, 4-bit out plus invalid flag.
  - It is the shared resource, instantiated exactly once.
- Counter, FSM, source and result registers live in bcd_ex3_seq_ctrl.

Test Plan:
- Basic conversion, DIGITS=4, out_ready tied 1: accept 16'h1234 → out_ex3=16'h4567, out_err=0. out_valid rises 4 cycles after the accept edge and is high for exactly 1 cycle.
- Boundary digits: 16'h9900 → 16'hCC33, out_err=0. 16'h0000 → 16'h3333.
- Invalid digit: 16'h12A4 → out_ex3=16'h45F7, out_err=1. Next word 16'h0001 → 16'h3334, out_err=0, proving the error flag does not stick across words.
- Backpressure: hold out_ready=0 for 5 cycles in DONE:
  - out_valid, out_ex3 and out_err stay stable; in_ready=0.
  - A new in_valid pulse is ignored.
  - Release out_ready → IDLE, then in_ready=1 the next cycle.
- Reset mid-operation: assert rst for 1 cycle at the 2nd CONV cycle of 16'h5678 → all outputs 0, in_ready=1 next cycle. Then 16'h0102 → 16'h3435.
- Exhaustive single digit with DIGITS=1: inputs 0..15 → outputs i+3 for i≤9 with err=0; 4'hF with err=1 for i≥10. Each result completes in 1 CONV cycle.
